img2col_col_reader: RTL and testbench

//  Downstream of the tensor RAM (ram_t1). Walks a KxK window over an IMG_H x IMG_W tensor stored row-major
//  at BASE_ADDR and reads each window element through the RAM's single read/write port.

---
 rtl/img2col_pkg.sv | 57 +++++
 rtl/img2col_skid_fifo.sv | 65 ++++++
 rtl/img2col_col_reader.sv | 163 ++++++++++++++++
 tb/tb_img2col_col_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// Shared types and helpers for the im2col column reader: FSM states, element tags,
// default geometry and the arithmetic used to size counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 12
`endif

package img2col_pkg;

  localparam int DATA_W = `DATA_WIDTH;
  localparam int ADDR_W = `ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic pad;
    logic eoc;
    logic eof;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  function automatic int out_dim(input int dim, input int k, input int stride, input int pad);
    return (dim + 2 * pad - k) / stride + 1;
  endfunction

  // A counter that only ever holds 0 still needs one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_IMG_H  = 4;
  localparam int DEF_IMG_W  = 4;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_PAD    = 0;

  localparam int OH = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE, DEF_PAD);
  localparam int OW = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE, DEF_PAD);
  localparam int KK = DEF_K * DEF_K;

  localparam int OY_W = cnt_w(OH);
  localparam int OX_W = cnt_w(OW);
  localparam int KC_W = cnt_w(DEF_K);

endpackage

// File: rtl/img2col_skid_fifo.sv
// Two-entry show-ahead FIFO for element data and tags; an entry arriving into an empty
// FIFO is presented in the same cycle so the stream runs at one element per cycle.
module img2col_skid_fifo
  import img2col_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       count
);

  logic [DW-1:0]    data_mem [2];
  logic [TAG_W-1:0] tag_mem  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign out_valid = (count != 2'd0) || in_valid;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_data = '0;
    out_tag  = '0;
    if (count != 2'd0) begin
      out_data = data_mem[rd_ptr];
      out_tag  = tag_mem[rd_ptr];
    end else if (in_valid) begin
      out_data = in_data;
      out_tag  = in_tag;
    end
  end

  // Every arrival is written even when it is popped straight through; both pointers then
  // advance together, so the bypass case needs no special handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      tag_mem[0]  <= '0;
      tag_mem[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (in_valid) begin
        data_mem[wr_ptr] <= in_data;
        tag_mem[wr_ptr]  <= in_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/img2col_col_reader.sv
// Walks a KxK window over a row-major tensor in RAM and streams one im2col column per
// output pixel, inserting zeros for padding and absorbing read latency and backpressure.
module img2col_col_reader
  import img2col_pkg::*;
#(
  parameter int IMG_H     = DEF_IMG_H,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int K         = DEF_K,
  parameter int STRIDE    = DEF_STRIDE,
  parameter int PAD       = DEF_PAD,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [`ADDR_SIZE-1:0]  ram_addra,
  output logic                   ram_ena,
  output logic                   ram_wea,
  input  logic [`DATA_WIDTH-1:0] ram_douta,
  output logic [`DATA_WIDTH-1:0] col_data,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic                   col_eoc,
  output logic                   col_eof
);

  localparam int DW     = `DATA_WIDTH;
  localparam int AW     = `ADDR_SIZE;
  localparam int OH_P   = out_dim(IMG_H, K, STRIDE, PAD);
  localparam int OW_P   = out_dim(IMG_W, K, STRIDE, PAD);
  localparam int YW     = cnt_w(OH_P);
  localparam int XW     = cnt_w(OW_P);
  localparam int KW     = cnt_w(K);
  localparam int SW     = $clog2(max2(IMG_H, IMG_W) + 2 * PAD) + 2;

  localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
  localparam logic [XW-1:0] OX_LAST = XW'(OW_P - 1);
  localparam logic [YW-1:0] OY_LAST = YW'(OH_P - 1);

  state_t state, state_next;

  logic [YW-1:0] oy;
  logic [XW-1:0] ox;
  logic [KW-1:0] ky, kx;

  logic signed [SW-1:0] iy, ix;
  int                   iy_i, ix_i;

  logic    issue, is_pad, last_elem, win_last, drained;
  logic    inflight;
  tag_t    issue_tag, inflight_tag, out_tag;
  logic [1:0]    fifo_count, occupancy;
  logic [DW-1:0] out_data;
  logic          out_valid, pop;

  assign occupancy = fifo_count + {1'b0, inflight};
  assign issue     = (state == RUN) && (occupancy < 2'd2);
  assign win_last  = (kx == K_LAST) && (ky == K_LAST);
  assign last_elem = win_last && (ox == OX_LAST) && (oy == OY_LAST);
  assign pop       = out_valid && col_ready;

  always_comb begin
    iy     = SW'(int'(oy) * STRIDE + int'(ky) - PAD);
    ix     = SW'(int'(ox) * STRIDE + int'(kx) - PAD);
    iy_i   = int'(iy);
    ix_i   = int'(ix);
    is_pad = (iy_i < 0) || (iy_i >= IMG_H) || (ix_i < 0) || (ix_i >= IMG_W);
  end

  assign issue_tag = '{pad: is_pad, eoc: win_last, eof: last_elem};
  assign ram_ena   = issue && !is_pad;
  assign ram_addra = ram_ena ? AW'(BASE_ADDR + iy_i * IMG_W + ix_i) : '0;
  assign ram_wea   = 1'b0;

  // Window counters: kx innermost, then ky, ox, oy; they wrap back to 0 after the
  // frame's final element so the next frame starts from the origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (issue) begin
      if (kx == K_LAST) begin
        kx <= '0;
        if (ky == K_LAST) begin
          ky <= '0;
          if (ox == OX_LAST) begin
            ox <= '0;
            oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
        end else begin
          ky <= ky + 1'b1;
        end
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_tag <= issue_tag;
      end
    end
  end

  // Drained means nothing is left once this cycle's handshake completes, which lets
  // done follow the final accept by exactly one cycle.
  assign drained = (occupancy == {1'b0, pop});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue && last_elem) state_next = DRAIN;
      DRAIN:   if (drained) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  img2col_skid_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (ram_douta),
    .in_tag    (inflight_tag),
    .out_ready (col_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .count     (fifo_count)
  );

  assign col_valid = out_valid;
  assign col_data  = out_tag.pad ? '0 : out_data;
  assign col_eoc   = out_valid && out_tag.eoc;
  assign col_eof   = out_valid && out_tag.eof;

endmodule

// File: tb/tb_img2col_col_reader.sv
// Scoreboard bench for img2col_col_reader: three configurations against a mem[i]=i RAM,
// with directed frames, random backpressure, mid-frame reset and a spurious start.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 12
`endif

module tb_img2col_col_reader;

  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_SIZE;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eoc;
    logic          eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic          start[3], col_ready[3], busy[3], done[3];
  logic          ram_ena[3], ram_wea[3], col_valid[3], col_eoc[3], col_eof[3];
  logic [AW-1:0] ram_addra[3];
  logic [DW-1:0] ram_douta[3], col_data[3];

  exp_t q0[$], q1[$], q2[$];
  exp_t mon_e;
  int   hv[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int accepted[3], reads[3], dones[3], start_cyc[3], first_valid[3], last_acc[3], done_cyc[3];
  logic [DW-1:0] got[3][256];
  logic          stall_prev[3];
  logic [DW-1:0] data_prev[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  img2col_col_reader #(.IMG_H(4), .IMG_W(4), .K(3), .STRIDE(1), .PAD(0), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .ram_addra(ram_addra[0]), .ram_ena(ram_ena[0]), .ram_wea(ram_wea[0]), .ram_douta(ram_douta[0]),
    .col_data(col_data[0]), .col_valid(col_valid[0]), .col_ready(col_ready[0]),
    .col_eoc(col_eoc[0]), .col_eof(col_eof[0]));

  img2col_col_reader #(.IMG_H(4), .IMG_W(4), .K(3), .STRIDE(1), .PAD(1), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .ram_addra(ram_addra[1]), .ram_ena(ram_ena[1]), .ram_wea(ram_wea[1]), .ram_douta(ram_douta[1]),
    .col_data(col_data[1]), .col_valid(col_valid[1]), .col_ready(col_ready[1]),
    .col_eoc(col_eoc[1]), .col_eof(col_eof[1]));

  img2col_col_reader #(.IMG_H(4), .IMG_W(4), .K(2), .STRIDE(2), .PAD(0), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .ram_addra(ram_addra[2]), .ram_ena(ram_ena[2]), .ram_wea(ram_wea[2]), .ram_douta(ram_douta[2]),
    .col_data(col_data[2]), .col_valid(col_valid[2]), .col_ready(col_ready[2]),
    .col_eoc(col_eoc[2]), .col_eof(col_eof[2]));

  // RAM model with mem[i] = i and one cycle of read latency.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) ram_douta[d] <= '0;
      else if (ram_ena[d]) ram_douta[d] <= DW'(ram_addra[d]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int qSize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qPop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qPush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qFlush(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Reference walk of the window for each instance's geometry.
  task automatic pushModel(input int d);
    int k, s, p, oh, ow, iy, ix;
    exp_t e;
    k  = (d == 2) ? 2 : 3;
    s  = (d == 2) ? 2 : 1;
    p  = (d == 1) ? 1 : 0;
    oh = (4 + 2 * p - k) / s + 1;
    ow = oh;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            iy = oy * s + ky - p;
            ix = ox * s + kx - p;
            e.data = (iy >= 0 && iy < 4 && ix >= 0 && ix < 4) ? DW'(iy * 4 + ix) : '0;
            e.eoc  = (ky == k - 1) && (kx == k - 1);
            e.eof  = e.eoc && (oy == oh - 1) && (ox == ow - 1);
            qPush(d, e);
          end
  endtask

  // Monitor: pops the scoreboard on every handshake and watches stall stability.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        if (stall_prev[d]) begin
          checkOutput($sformatf("dut%0d_hold_valid", d), 32'(col_valid[d]), 32'd1);
          checkOutput($sformatf("dut%0d_hold_data", d), 32'(col_data[d]), 32'(data_prev[d]));
        end
        if (ram_ena[d]) reads[d]++;
        if (done[d]) begin
          dones[d]++;
          done_cyc[d] = cyc;
        end
        if (col_valid[d] && first_valid[d] < 0) first_valid[d] = cyc;
        if (col_valid[d] && col_ready[d]) begin
          if (qSize(d) == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL dut%0d_extra_elem: got data %0d, expected no element", d, col_data[d]);
          end else begin
            mon_e = qPop(d);
            checkOutput($sformatf("dut%0d_e%0d_data", d, accepted[d]), 32'(col_data[d]), 32'(mon_e.data));
            checkOutput($sformatf("dut%0d_e%0d_eoc", d, accepted[d]), 32'(col_eoc[d]), 32'(mon_e.eoc));
            checkOutput($sformatf("dut%0d_e%0d_eof", d, accepted[d]), 32'(col_eof[d]), 32'(mon_e.eof));
          end
          if (accepted[d] < 256) got[d][accepted[d]] = col_data[d];
          accepted[d]++;
          last_acc[d] = cyc;
        end
        stall_prev[d] = col_valid[d] && !col_ready[d];
        data_prev[d]  = col_data[d];
      end else begin
        stall_prev[d] = 1'b0;
      end
    end
  end

  task automatic clearStats(input int d);
    accepted[d]    = 0;
    reads[d]       = 0;
    dones[d]       = 0;
    first_valid[d] = -1;
    last_acc[d]    = -1;
    done_cyc[d]    = -1;
  endtask

  // Runs one frame on instance d; called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input int d, input bit rnd, input bit extra,
                               input int exp_n, input int exp_reads);
    bit seen;
    clearStats(d);
    pushModel(d);
    col_ready[d] = 1'b1;
    start[d]     = 1'b1;
    start_cyc[d] = cyc;
    @(posedge clk); #1;
    start[d] = 1'b0;
    checkOutput($sformatf("dut%0d_busy_after_start", d), 32'(busy[d]), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      col_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start[d]     = (extra && c == 12) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (dones[d] != 0) seen = 1'b1;
    end
    start[d]     = 1'b0;
    col_ready[d] = 1'b1;
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL dut%0d_done_timeout: got no done pulse, expected one within 3000 cycles", d);
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput($sformatf("dut%0d_elem_count", d), 32'(accepted[d]), 32'(exp_n));
    checkOutput($sformatf("dut%0d_ram_reads", d), 32'(reads[d]), 32'(exp_reads));
    checkOutput($sformatf("dut%0d_done_pulses", d), 32'(dones[d]), 32'd1);
    checkOutput($sformatf("dut%0d_queue_left", d), 32'(qSize(d)), 32'd0);
    checkOutput($sformatf("dut%0d_done_delay", d), 32'(done_cyc[d] - last_acc[d]), 32'd1);
    checkOutput($sformatf("dut%0d_first_valid_lat", d), 32'(first_valid[d] - start_cyc[d]), 32'd2);
    checkOutput($sformatf("dut%0d_busy_idle", d), 32'(busy[d]), 32'd0);
    qFlush(d);
  endtask

  task automatic checkHand(input int d, input int base, input string name);
    for (int i = 0; i < hv.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), 32'(got[d][base + i]), 32'(hv[i]));
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_busy"}, 32'(busy[0]), 32'd0);
    checkOutput({name, "_done"}, 32'(done[0]), 32'd0);
    checkOutput({name, "_ram_ena"}, 32'(ram_ena[0]), 32'd0);
    checkOutput({name, "_ram_addra"}, 32'(ram_addra[0]), 32'd0);
    checkOutput({name, "_ram_wea"}, 32'(ram_wea[0]), 32'd0);
    checkOutput({name, "_col_valid"}, 32'(col_valid[0]), 32'd0);
    checkOutput({name, "_col_data"}, 32'(col_data[0]), 32'd0);
    checkOutput({name, "_col_eoc"}, 32'(col_eoc[0]), 32'd0);
    checkOutput({name, "_col_eof"}, 32'(col_eof[0]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d]      = 1'b0;
      col_ready[d]  = 1'b1;
      stall_prev[d] = 1'b0;
      start_cyc[d]  = 0;
      clearStats(d);
    end
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] case 1: 4x4, K=3, S=1, P=0");
    applyStimulus(0, 1'b0, 1'b0, 36, 36);
    hv = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    checkHand(0, 0, "c1_col0");
    hv = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    checkHand(0, 27, "c1_col3");

    $display("[TB] case 2: 4x4, K=3, S=1, P=1");
    applyStimulus(1, 1'b0, 1'b0, 144, 100);
    hv = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
    checkHand(1, 0, "c2_col0");
    hv = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
    checkHand(1, 135, "c2_col15");

    $display("[TB] case 3: 4x4, K=2, S=2, P=0");
    applyStimulus(2, 1'b0, 1'b0, 16, 16);
    hv = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    checkHand(2, 0, "c3_all");

    $display("[TB] case 4: random backpressure");
    applyStimulus(0, 1'b1, 1'b0, 36, 36);
    hv = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    checkHand(0, 27, "c4_col3");

    $display("[TB] case 5: reset mid-frame");
    clearStats(0);
    pushModel(0);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int c = 0; c < 200 && accepted[0] < 10; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("c5_partial_count", 32'(accepted[0]), 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("c5_after_reset");
    rst = 1'b0;
    qFlush(0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 36, 36);
    hv = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    checkHand(0, 0, "c5_col0");

    $display("[TB] case 6: second start mid-frame");
    applyStimulus(0, 1'b0, 1'b1, 36, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
